// File: rtl/fnd_scan_controller_pkg.sv
// fnd_scan_controller_pkg: shared constants, converter state encoding and display helpers
package fnd_scan_controller_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int MAX_BIN = 9999;
    localparam int BIN_W = 14;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

    function automatic logic [BIN_W-1:0] sat_bin(input logic [BIN_W-1:0] v);
        return (v > BIN_W'(MAX_BIN)) ? BIN_W'(MAX_BIN) : v;
    endfunction

    // Digit k is blank when it and every higher digit are zero; the ones digit never blanks.
    function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [4*NUM_DIGITS-1:0] bcd);
        logic z;
        z = 1'b1;
        blank_mask = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            z = z & (bcd[4*k +: 4] == 4'd0);
            blank_mask[k] = z;
        end
    endfunction
endpackage

// File: rtl/fnd_scan_controller_if.sv
// fnd_scan_controller_if: value inputs and scanned digit outputs of the FND scan controller
interface fnd_scan_controller_if;
    import fnd_scan_controller_pkg::*;
    logic [BIN_W-1:0] i_value;
    logic [BIN_W-1:0] i_clock_value;
    logic [NUM_DIGITS-1:0] o_digit_select;
    logic [3:0] o_value;
    logic [3:0] o_clock_value;
    logic o_frame;

    modport master (
        output i_value, i_clock_value,
        input o_digit_select, o_value, o_clock_value, o_frame
    );
    modport slave (
        input i_value, i_clock_value,
        output o_digit_select, o_value, o_clock_value, o_frame
    );
endinterface

// File: rtl/bin2bcd_dd.sv
// bin2bcd_dd: double-dabble binary-to-BCD datapath, one iteration per shift cycle
module bin2bcd_dd
    import fnd_scan_controller_pkg::*;
(
    input logic clk,
    input logic rst_n,
    input logic load,
    input logic shift,
    input logic [BIN_W-1:0] bin,
    output logic [4*NUM_DIGITS-1:0] bcd
);
    logic [BIN_W-1:0] sr;
    logic [4*NUM_DIGITS-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int k = 0; k < NUM_DIGITS; k++)
            adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
            bcd <= '0;
        end else if (load) begin
            sr <= sat_bin(bin);
            bcd <= '0;
        end else if (shift) begin
            {bcd, sr} <= {adj, sr} << 1;
        end
    end
endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: multiplexed 4-digit scan with per-frame binary-to-BCD conversion of two values
module fnd_scan_controller
    import fnd_scan_controller_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int SCAN_HZ = 1000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input logic i_clk,
    input logic i_reset,
    fnd_scan_controller_if.slave bus
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(BIN_W);
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [TW-1:0] iter;
    conv_state_t state;
    logic tick, frame;
    logic [DW-1:0] val_bcd, clk_bcd, val_pend, clk_pend, val_disp, clk_disp;
    logic [NUM_DIGITS-1:0] val_blank, clk_blank;

    assign tick = cnt == CW'(DIV - 1);
    assign frame = tick && idx == IW'(NUM_DIGITS - 1);

    bin2bcd_dd u_val (
        .clk(i_clk), .rst_n(i_reset), .load(state == LOAD), .shift(state == SHIFT),
        .bin(bus.i_value), .bcd(val_bcd)
    );
    bin2bcd_dd u_clk (
        .clk(i_clk), .rst_n(i_reset), .load(state == LOAD), .shift(state == SHIFT),
        .bin(bus.i_clock_value), .bcd(clk_bcd)
    );

    // Conversion lands in pending; the display only takes it at a frame boundary.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt <= '0;
            idx <= '0;
            iter <= '0;
            state <= IDLE;
            val_pend <= '0;
            clk_pend <= '0;
            val_disp <= '0;
            clk_disp <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            idx <= tick ? idx + 1'b1 : idx;
            if (frame) begin
                val_disp <= val_pend;
                clk_disp <= clk_pend;
            end
            case (state)
                IDLE: state <= frame ? LOAD : IDLE;
                LOAD: begin
                    iter <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    iter <= iter + 1'b1;
                    state <= (iter == TW'(BIN_W - 1)) ? DONE : SHIFT;
                end
                DONE: begin
                    val_pend <= val_bcd;
                    clk_pend <= clk_bcd;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        val_blank = BLANK_LEADING ? blank_mask(val_disp) : '0;
        clk_blank = BLANK_LEADING ? blank_mask(clk_disp) : '0;
        bus.o_digit_select = i_reset ? ~(NUM_DIGITS'(1) << idx) : '1;
        bus.o_frame = frame;
        bus.o_value = val_blank[idx] ? BLANK_CODE : val_disp[{idx, 2'b00} +: 4];
        bus.o_clock_value = clk_blank[idx] ? BLANK_CODE : clk_disp[{idx, 2'b00} +: 4];
    end
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: randomized self-checking bench against a frame-level decimal display model
module tb_fnd_scan_controller;
    logic clk = 1'b0;
    logic i_reset = 1'b0;
    always #5 clk = ~clk;

    fnd_scan_controller_if bus();
    fnd_scan_controller #(.CLK_HZ(64), .SCAN_HZ(2), .BLANK_LEADING(1'b1)) dut (
        .i_clk(clk), .i_reset(i_reset), .bus(bus)
    );

    int tests = 0;
    int failed = 0;
    int k = 0;
    int samp_v[512];
    int samp_c[512];
    logic [3:0] e_sel, e_v, e_cv;
    logic e_fr;

    // k = rising edges since reset release; digit period 32, frame period 128.
    // Inputs are sampled just after each frame boundary and shown during the following frame.
    always @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            k = 0;
            foreach (samp_v[i]) begin
                samp_v[i] = 0;
                samp_c[i] = 0;
            end
        end else begin
            k++;
            if (k % 128 == 1 && k > 128) begin
                samp_v[k / 128] = (int'(bus.i_value) > 9999) ? 9999 : int'(bus.i_value);
                samp_c[k / 128] = (int'(bus.i_clock_value) > 9999) ? 9999 : int'(bus.i_clock_value);
            end
        end
    end

    function automatic logic [3:0] digit(int a, int ix);
        int p = 1;
        for (int i = 0; i < ix; i++) p *= 10;
        return (ix > 0 && a < p) ? 4'hF : 4'((a / p) % 10);
    endfunction

    function automatic void predict();
        int ix = (k / 32) % 4;
        int m = k / 128;
        int a = (m == 0) ? 0 : samp_v[m - 1];
        int b = (m == 0) ? 0 : samp_c[m - 1];
        e_sel = ~(4'b0001 << ix);
        e_fr = (k % 128 == 127);
        e_v = digit(a, ix);
        e_cv = digit(b, ix);
    endfunction

    task automatic test_reset();
        i_reset = 1'b0;
        bus.i_value = '0;
        bus.i_clock_value = '0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({bus.o_digit_select, bus.o_frame} !== 5'b11110) begin
                failed++;
                $display("FAIL reset_hold sel=%b frame=%b expected 1111/0", bus.o_digit_select, bus.o_frame);
            end
        end
        i_reset = 1'b1;
        #1;
        tests++;
        if ({bus.o_digit_select, bus.o_value, bus.o_clock_value} !== 12'b1110_0000_0000) begin
            failed++;
            $display("FAIL first_cycle sel=%b v=%h cv=%h expected 1110/0/0",
                     bus.o_digit_select, bus.o_value, bus.o_clock_value);
        end
    endtask

    task automatic test_scan_sequence();
        repeat (5 * 32 + 10) begin
            @(negedge clk);
            predict();
            tests++;
            if ({bus.o_digit_select, bus.o_frame} !== {e_sel, e_fr}) begin
                failed++;
                $display("FAIL scan k=%0d sel=%b frame=%b expected %b/%b", k, bus.o_digit_select, bus.o_frame, e_sel, e_fr);
            end
        end
    endtask

    task automatic test_fixed_values();
        int fv[5] = '{1234, 5, 0, 12000, 9999};
        int fc[5] = '{907, 0, 5, 16383, 10000};
        for (int n = 0; n < 5; n++) begin
            bus.i_value = 14'(fv[n]);
            bus.i_clock_value = 14'(fc[n]);
            repeat (3 * 128) begin
                @(negedge clk);
                predict();
                tests++;
                if ({bus.o_digit_select, bus.o_frame, bus.o_value, bus.o_clock_value} !== {e_sel, e_fr, e_v, e_cv}) begin
                    failed++;
                    $display("FAIL fixed in=%0d/%0d k=%0d got %b/%b/%h/%h expected %b/%b/%h/%h", fv[n], fc[n], k,
                             bus.o_digit_select, bus.o_frame, bus.o_value, bus.o_clock_value, e_sel, e_fr, e_v, e_cv);
                end
            end
        end
    endtask

    task automatic test_mid_frame_change();
        bus.i_value = 14'd1111;
        bus.i_clock_value = 14'd1111;
        for (int n = 0; n < 2 * 384; n++) begin
            if (n == 384) begin
                while (k % 128 != 64) @(negedge clk);
                bus.i_value = 14'd2222;
                bus.i_clock_value = 14'd2222;
            end
            @(negedge clk);
            predict();
            tests++;
            if ({bus.o_digit_select, bus.o_frame, bus.o_value, bus.o_clock_value} !== {e_sel, e_fr, e_v, e_cv}) begin
                failed++;
                $display("FAIL mid_frame k=%0d got %b/%b/%h/%h expected %b/%b/%h/%h", k,
                         bus.o_digit_select, bus.o_frame, bus.o_value, bus.o_clock_value, e_sel, e_fr, e_v, e_cv);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            bus.i_value = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 99)) : 14'($urandom_range(0, 16383));
            bus.i_clock_value = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 999)) : 14'($urandom_range(0, 16383));
            repeat ($urandom_range(60, 300)) begin
                @(negedge clk);
                predict();
                tests++;
                if ({bus.o_digit_select, bus.o_frame, bus.o_value, bus.o_clock_value} !== {e_sel, e_fr, e_v, e_cv}) begin
                    failed++;
                    $display("FAIL random k=%0d got %b/%b/%h/%h expected %b/%b/%h/%h", k,
                             bus.o_digit_select, bus.o_frame, bus.o_value, bus.o_clock_value, e_sel, e_fr, e_v, e_cv);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int waited = 0;
        bus.i_value = 14'd4321;
        bus.i_clock_value = 14'd8765;
        repeat (300) @(negedge clk);
        while (bus.o_frame !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (bus.o_frame !== 1'b1) begin
            failed++;
            $display("FAIL abort_frame_wait frame=%b after %0d cycles expected 1", bus.o_frame, waited);
        end
        repeat (6) @(negedge clk);
        i_reset = 1'b0;
        repeat (3) begin
            #1;
            tests++;
            if ({bus.o_digit_select, bus.o_frame} !== 5'b11110) begin
                failed++;
                $display("FAIL abort_hold sel=%b frame=%b expected 1111/0", bus.o_digit_select, bus.o_frame);
            end
            @(negedge clk);
        end
        bus.i_value = 14'($urandom_range(0, 9));
        bus.i_clock_value = 14'($urandom_range(10, 9999));
        i_reset = 1'b1;
        repeat (3 * 128 + 10) begin
            @(negedge clk);
            predict();
            tests++;
            if ({bus.o_digit_select, bus.o_frame, bus.o_value, bus.o_clock_value} !== {e_sel, e_fr, e_v, e_cv}) begin
                failed++;
                $display("FAIL abort k=%0d got %b/%b/%h/%h expected %b/%b/%h/%h", k,
                         bus.o_digit_select, bus.o_frame, bus.o_value, bus.o_clock_value, e_sel, e_fr, e_v, e_cv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_fixed_values();
        test_mid_frame_change();
        test_random();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, per-digit refresh rate in Hz; divisor DIV = CLK_HZ/SCAN_HZ SHALL be >= 32.
REQ-003 Parameter BLANK_LEADING, default 1, 1 = leading-zero digits output BLANK_CODE.
REQ-004 i_clk  input  1  single system clock, rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_value  input  14  fan-mode binary value, 0..16383.
REQ-007 i_clock_value  input  14  clock-mode binary value, 0..16383.
REQ-008 o_digit_select  output  4  active-low digit anodes, one-hot-low.
REQ-009 o_value  output  4  BCD digit of i_value for the selected position, or BLANK_CODE.
REQ-010 o_clock_value  output  4  BCD digit of i_clock_value for the selected position, or BLANK_CODE.
REQ-011 o_frame  output  1  one-cycle pulse on every digit 3 -> digit 0 wrap.

Function
REQ-012 Prescaler SHALL count 0..DIV-1 and assert an internal scan tick for one cycle at DIV-1, then wrap to 0.
REQ-013 Digit index SHALL advance 0->1->2->3->0 on each scan tick; o_digit_select SHALL be 1110, 1101, 1011, 0111 for index 0..3 (index 0 = ones).
REQ-014 o_frame SHALL pulse in the cycle the index wraps 3->0.
REQ-015 Converter FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE->LOAD on o_frame; LOAD captures both inputs, saturating any value > 9999 to 9999.
REQ-017 SHIFT SHALL run exactly 14 double-dabble iterations, one per cycle, on both values in parallel: add 3 to each BCD nibble >= 5, then shift left.
REQ-018 DONE SHALL write both 16-bit BCD results to pending registers, then return to IDLE; total LOAD-to-DONE latency is 16 cycles.
REQ-019 Display registers SHALL load from pending registers only on o_frame; digits SHALL never change within a frame.
REQ-020 Input-to-display latency SHALL be one full frame: a value sampled at frame N appears from frame N+1.
REQ-021 o_frame occurring while the FSM is not IDLE SHALL be ignored and SHALL NOT restart the conversion; DIV >= 32 makes this unreachable in normal use.
REQ-022 With BLANK_LEADING = 1, a digit SHALL output BLANK_CODE when it and all higher digits are 0, except index 0, which always shows its digit.
REQ-023 o_value and o_clock_value SHALL be combinational selects from the display registers by digit index.

Reset
REQ-024 While i_reset = 0: prescaler = 0, index = 0, FSM = IDLE, and pending and display registers = 0.
REQ-025 While i_reset = 0: o_digit_select = 1111 (all off) and o_frame = 0.
REQ-026 First cycle after release: o_digit_select = 1110, o_value = o_clock_value = 0.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion; no partial result SHALL reach the pending registers.

Structure
REQ-028 A shared package SHALL hold NUM_DIGITS = 4, BLANK_CODE = 4'hF, MAX_BIN = 9999, BIN_W = 14, and the FSM state encoding.
REQ-029 The double-dabble datapath SHALL be one sub-module, bin2bcd_dd, instantiated twice and driven by the shared FSM control.
REQ-030 Outputs SHALL connect directly to the downstream BCD-to-FND decoder, which renders BLANK_CODE as all segments off.

Verification (CLK_HZ = 64, SCAN_HZ = 2, so DIV = 32)
REQ-031 Reset, release -> o_digit_select sequence is 1110, 1101, 1011, 0111, 1110, with each step 32 cycles apart and o_frame pulsing at the wrap.
REQ-032 i_value = 1234, i_clock_value = 0907, held 3 frames -> from frame 2, o_value per index = 4, 3, 2, 1 and o_clock_value = 7, 0, 9, BLANK (F).
REQ-033 i_value = 5 -> o_value = 5, F, F, F; i_value = 0 -> 0, F, F, F.
REQ-034 i_value = 12000 -> displays 9, 9, 9, 9.
REQ-035 i_value changed mid-frame from 1111 to 2222 -> no frame shows mixed digits; 2222 appears in the first frame after the next sampling frame.
REQ-036 i_reset asserted 5 cycles after LOAD, released -> o_digit_select = 1111 during reset, displays 0, F, F, F next frame, and the old value does not reappear.
